// File: rtl/cu_if.sv
// cu_if: opcode set shared with ir, plus the control bundle between cu and the t5 datapath.
`ifndef CU_OPCODES
`define CU_OPCODES
`define CU_LDA  8'h01
`define CU_ADD  8'h02
`define CU_STA  8'h03
`define CU_CLA  8'h04
`define CU_COM  8'h05
`define CU_SHR  8'h06
`define CU_CSL  8'h07
`define CU_JMP  8'h08
`define CU_BAN  8'h09
`define CU_STOP 8'h0a
`endif

interface cu_if;
    logic [7:0] op;
    logic       acc_neg;
    logic       mar_load;
    logic       mar_sel_pc;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_load;
    logic [2:0] alu_op;

    modport master (
        input  op, acc_neg,
        output mar_load, mar_sel_pc, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load, alu_op
    );

    modport slave (
        output op, acc_neg,
        input  mar_load, mar_sel_pc, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load, alu_op
    );
endinterface

// File: rtl/cu.sv
// cu: multi-cycle fetch/decode/execute sequencer for the t5 accumulator CPU.
module cu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    cu_if.master       bus,
    output logic       halted,
    output logic       illegal,
    output logic [7:0] icount
);
    typedef enum logic [2:0] {IDLE, F0, F1, F2, D, E0, E1, HALT} state_t;

    state_t state, nxt;
    logic   retire;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    // Every instruction, stop and illegal included, retires on its last-state exit.
    assign retire = (nxt == F0 && (state == D || state == E0 || state == E1)) ||
                    (nxt == HALT && state == D);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)      icount <= '0;
        else if (retire) icount <= icount + 8'd1;

    always_comb begin
        nxt            = state;
        bus.mar_load   = 1'b0;
        bus.mar_sel_pc = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.ir_load    = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.pc_load    = 1'b0;
        bus.acc_load   = 1'b0;
        bus.alu_op     = 3'd0;
        halted         = 1'b0;
        illegal        = 1'b0;
        case (state)
            IDLE: nxt = start ? F0 : IDLE;
            F0: begin
                bus.mar_load   = 1'b1;
                bus.mar_sel_pc = 1'b1;
                nxt            = F1;
            end
            F1: begin
                bus.mem_rd = 1'b1;
                nxt        = F2;
            end
            F2: begin
                bus.ir_load = 1'b1;
                bus.pc_inc  = 1'b1;
                nxt         = D;
            end
            D: begin
                nxt = F0;
                case (bus.op)
                    `CU_CLA: begin bus.acc_load = 1'b1; bus.alu_op = 3'd2; end
                    `CU_COM: begin bus.acc_load = 1'b1; bus.alu_op = 3'd3; end
                    `CU_SHR: begin bus.acc_load = 1'b1; bus.alu_op = 3'd4; end
                    `CU_CSL: begin bus.acc_load = 1'b1; bus.alu_op = 3'd5; end
                    `CU_JMP: bus.pc_load = 1'b1;
                    `CU_BAN: bus.pc_load = bus.acc_neg;
                    `CU_LDA, `CU_ADD, `CU_STA: begin
                        bus.mar_load = 1'b1;
                        nxt          = E0;
                    end
                    `CU_STOP: nxt = HALT;
                    default:  illegal = 1'b1;
                endcase
            end
            E0: begin
                bus.mem_wr = bus.op == `CU_STA;
                bus.mem_rd = bus.op != `CU_STA;
                nxt        = bus.op == `CU_STA ? F0 : E1;
            end
            E1: begin
                bus.acc_load = 1'b1;
                bus.alu_op   = bus.op == `CU_ADD ? 3'd1 : 3'd0;
                nxt          = F0;
            end
            HALT: halted = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_cu.sv
// tb_cu: scoreboard bench for cu; a small ir model feeds op, expected per-cycle strobes are queued per instruction.
`ifndef CU_OPCODES
`define CU_OPCODES
`define CU_LDA  8'h01
`define CU_ADD  8'h02
`define CU_STA  8'h03
`define CU_CLA  8'h04
`define CU_COM  8'h05
`define CU_SHR  8'h06
`define CU_CSL  8'h07
`define CU_JMP  8'h08
`define CU_BAN  8'h09
`define CU_STOP 8'h0a
`endif

module tb_cu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       halted, illegal;
    logic [7:0] icount;

    cu_if ifc ();

    cu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (ifc.master),
        .halted  (halted),
        .illegal (illegal),
        .icount  (icount)
    );

    always #5 clk = ~clk;

    // vector layout: mar_load sel rd wr ir_load pc_inc pc_load acc_load alu_op[2:0] halted illegal
    localparam logic [12:0] ML = 13'h1000, SEL = 13'h0800, RD = 13'h0400, WR = 13'h0200;
    localparam logic [12:0] IRL = 13'h0100, PCI = 13'h0080, PCL = 13'h0040, ACL = 13'h0020;
    localparam logic [12:0] HLT = 13'h0002, ILL = 13'h0001;

    typedef struct packed {
        logic [12:0] v;
        logic [7:0]  ic;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] op_q[$];
    logic [7:0] ic = 8'd0;
    int         total = 0;
    int         bad = 0;

    // ir model: loads the next program opcode whenever cu strobes ir_load.
    always @(posedge clk)
        if (ifc.ir_load && op_q.size() > 0) ifc.op <= op_q.pop_front();

    function automatic logic [12:0] alu(input int a);
        return 13'(a) << 2;
    endfunction

    function automatic logic [12:0] obs();
        return {ifc.mar_load, ifc.mar_sel_pc, ifc.mem_rd, ifc.mem_wr, ifc.ir_load, ifc.pc_inc,
                ifc.pc_load, ifc.acc_load, ifc.alu_op, halted, illegal};
    endfunction

    task automatic push(input logic [12:0] v);
        exp_q.push_back('{v: v, ic: ic});
    endtask

    task automatic issue(input logic [7:0] o, input logic neg);
        op_q.push_back(o);
        push(ML | SEL);
        push(RD);
        push(IRL | PCI);
        case (o)
            `CU_LDA:  begin push(ML); push(RD); push(ACL | alu(0)); end
            `CU_ADD:  begin push(ML); push(RD); push(ACL | alu(1)); end
            `CU_STA:  begin push(ML); push(WR); end
            `CU_CLA:  push(ACL | alu(2));
            `CU_COM:  push(ACL | alu(3));
            `CU_SHR:  push(ACL | alu(4));
            `CU_CSL:  push(ACL | alu(5));
            `CU_JMP:  push(PCL);
            `CU_BAN:  push(neg ? PCL : 13'h0);
            `CU_STOP: push(13'h0);
            default:  push(ILL);
        endcase
        ic = ic + 8'd1;
    endtask

    task automatic check_now(input string tag, input logic [12:0] ev, input logic [7:0] eic);
        total++;
        assert (obs() === ev) else begin
            bad++;
            $error("FAIL %s strobes got=%h want=%h t=%0t", tag, obs(), ev, $time);
        end
        total++;
        assert (icount === eic) else begin
            bad++;
            $error("FAIL %s icount got=%0d want=%0d t=%0t", tag, icount, eic, $time);
        end
    endtask

    task automatic run(input string tag, input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s scoreboard_empty got=%h want=none", tag, obs());
            end else begin
                e = exp_q.pop_front();
                check_now(tag, e.v, e.ic);
            end
        end
    endtask

    initial begin
        exp_t e;
        ifc.acc_neg = 1'b0;
        #13;
        check_now("reset", 13'h0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_now("idle", 13'h0, 8'd0);
        start = 1'b1;
        issue(`CU_LDA, 1'b0);
        issue(`CU_ADD, 1'b0);
        issue(`CU_STA, 1'b0);
        run("lda_add_sta", 17);
        start = 1'b0;
        ifc.acc_neg = 1'b1;
        issue(`CU_BAN, 1'b1);
        run("ban_neg", 4);
        ifc.acc_neg = 1'b0;
        issue(`CU_BAN, 1'b0);
        run("ban_pos", 4);
        issue(`CU_CLA, 1'b0);
        issue(`CU_COM, 1'b0);
        issue(`CU_SHR, 1'b0);
        issue(`CU_CSL, 1'b0);
        issue(`CU_JMP, 1'b0);
        run("alu_jmp", 20);
        issue(8'hee, 1'b0);
        run("illegal", 4);
        while (ic != 8'd255) issue(`CU_CLA, 1'b0);
        issue(`CU_COM, 1'b0);
        run("wrap", 4 * exp_q.size() / 4);
        issue(`CU_STA, 1'b0);
        run("sta_pre", 4);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_now("sta_e0", e.v, e.ic);
        rst_n = 1'b0;
        #1;
        check_now("sta_abort", 13'h0, 8'd0);
        exp_q.delete();
        op_q.delete();
        ic = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        issue(`CU_STOP, 1'b0);
        repeat (3) push(HLT);
        run("stop", 4);
        start = 1'b0;
        run("halt", 1);
        start = 1'b1;
        run("halt_start", 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("halt_reset", 13'h0, 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
